seq_fifo_ctrl_8x8b: RTL and testbench

Control stage that turns an external 8-entry x 8-bit, one-read/one-write register file into a first-in first-out queue with valid/ready handshakes on both sides. It sits directly in front of the register file. It drives the write port from the enqueue interface and drives the read address from the dequeue interface. The register file's combinational read data passes straight back out as the dequeue data.

---
 rtl/seq_fifo_ctrl_8x8b.sv | 92 +++++++++
 tb/tb_seq_fifo_ctrl_8x8b.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_fifo_ctrl_8x8b.sv
// -----------------------------------------------------------------------------
// seq_fifo_ctrl_8x8b
//
// Control stage that turns an external 8-entry x 8-bit register file (one
// write port, one combinational read port) into a FIFO with valid/ready
// handshakes on both sides. The block owns only the pointers and the
// occupancy count. The entry storage lives in the register file.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high reset
//   enq_val/enq_rdy/enq_msg   enqueue handshake and 8-bit entry data
//   deq_val/deq_rdy/deq_msg   dequeue handshake and head entry data
//   count           occupancy, 0..8
//   mem_write_en/addr/data    register-file write port
//   mem_read_addr   register-file read address (head slot)
//   mem_read_data   register-file combinational read data
// -----------------------------------------------------------------------------
module seq_fifo_ctrl_8x8b (
  input  logic       clk,
  input  logic       reset,
  input  logic       enq_val,
  output logic       enq_rdy,
  input  logic [7:0] enq_msg,
  output logic       deq_val,
  input  logic       deq_rdy,
  output logic [7:0] deq_msg,
  output logic [3:0] count,
  output logic       mem_write_en,
  output logic [2:0] mem_write_addr,
  output logic [7:0] mem_write_data,
  output logic [2:0] mem_read_addr,
  input  logic [7:0] mem_read_data
);

  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       empty;
  logic       full;
  logic       enq_go;
  logic       deq_go;

  // Flags depend only on the occupancy count.
  assign empty = (count == 4'd0);
  assign full  = (count == 4'd8);

  // The handshake outputs come from state alone. Neither one looks at
  // enq_val or deq_rdy, so the block adds no combinational path from input
  // to output across the handshake. As a result a full queue refuses an
  // enqueue even when a dequeue happens in the same cycle.
  assign enq_rdy = !full;
  assign deq_val = !empty;

  assign enq_go = enq_val & enq_rdy;
  assign deq_go = deq_val & deq_rdy;

  // Register-file drive. The write commits at the clock edge. The read is
  // combinational from rd_ptr, so an entry written in cycle N shows up on
  // deq_msg in cycle N+1 at the earliest.
  assign mem_write_en   = enq_go;
  assign mem_write_addr = wr_ptr;
  assign mem_write_data = enq_msg;
  assign mem_read_addr  = rd_ptr;
  assign deq_msg        = mem_read_data;

  // NOTE: the register file stores the entries, so reset clears only the
  // pointers and the count. Stale contents are harmless because no entry
  // is ever read before it has been written again.
  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      // The 3-bit pointers wrap from 7 to 0 on their own.
      if (enq_go) wr_ptr <= wr_ptr + 3'd1;
      if (deq_go) rd_ptr <= rd_ptr + 3'd1;

      // When enqueue and dequeue both happen, the count holds. This can
      // only occur when 0 < count < 8, so the write slot and the read slot
      // always differ.
      case ({enq_go, deq_go})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fifo_ctrl_8x8b.sv
// -----------------------------------------------------------------------------
// tb_seq_fifo_ctrl_8x8b
//
// Self-checking bench for seq_fifo_ctrl_8x8b. It holds a behavioural 8x8
// register file attached to the memory ports. A table of per-cycle vectors
// covers reset, fill, full blocking and drain. Hand-written sequences cover
// streaming at constant occupancy, empty-to-nonempty latency and a reset in
// the middle of a stream.
// -----------------------------------------------------------------------------
module tb_seq_fifo_ctrl_8x8b;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_val;
  logic       enq_rdy;
  logic [7:0] enq_msg;
  logic       deq_val;
  logic       deq_rdy;
  logic [7:0] deq_msg;
  logic [3:0] count;
  logic       mem_write_en;
  logic [2:0] mem_write_addr;
  logic [7:0] mem_write_data;
  logic [2:0] mem_read_addr;
  logic [7:0] mem_read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_fifo_ctrl_8x8b dut (
    .clk            (clk),
    .reset          (reset),
    .enq_val        (enq_val),
    .enq_rdy        (enq_rdy),
    .enq_msg        (enq_msg),
    .deq_val        (deq_val),
    .deq_rdy        (deq_rdy),
    .deq_msg        (deq_msg),
    .count          (count),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data)
  );

  // Behavioural register file: synchronous write, combinational read.
  logic [7:0] rf [8];
  always @(posedge clk) if (mem_write_en) rf[mem_write_addr] <= mem_write_data;
  assign mem_read_data = rf[mem_read_addr];

  typedef struct {
    logic       rst;
    logic       ev;
    logic [7:0] msg;
    logic       dr;
    logic       e_rdy;
    logic       e_val;
    logic       chk_msg;
    logic [7:0] e_msg;
    logic [3:0] e_cnt;
    logic       e_wen;
    logic [2:0] e_wa;
    logic [2:0] e_ra;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int rst, int ev, int msg, int dr, int e_rdy,
                              int e_val, int chk_msg, int e_msg, int e_cnt,
                              int e_wen, int e_wa, int e_ra);
    vec_t v;
    v.rst = rst[0];     v.ev = ev[0];       v.msg = msg[7:0];   v.dr = dr[0];
    v.e_rdy = e_rdy[0]; v.e_val = e_val[0]; v.chk_msg = chk_msg[0];
    v.e_msg = e_msg[7:0]; v.e_cnt = e_cnt[3:0]; v.e_wen = e_wen[0];
    v.e_wa = e_wa[2:0]; v.e_ra = e_ra[2:0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are checked
  // 1 time unit after that, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ev, input logic [7:0] msg,
                       input logic dr);
    reset   = rst;
    enq_val = ev;
    enq_msg = msg;
    deq_rdy = dr;
    #1;
  endtask

  logic [7:0] model[$];
  logic [7:0] m;

  initial begin
    // Table: 2 reset cycles with enq_val high, fill 0x10..0x17, a blocked
    // enqueue of 0xAA while full, its acceptance, then a full drain.
    add(1, 1, 8'h99, 0,  1, 0, 0, 0,  0, 1, 0, 0);
    add(1, 1, 8'h99, 0,  1, 0, 0, 0,  0, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'h10 + i, 0,  1, (i > 0), (i > 0), 8'h10,  i, 1, i, 0);
    add(0, 1, 8'hAA, 1,  0, 1, 1, 8'h10,  8, 0, 0, 0);
    add(0, 1, 8'hAA, 0,  1, 1, 1, 8'h11,  7, 1, 0, 1);
    for (int k = 0; k < 8; k++)
      add(0, 0, 8'h00, 1,  (k > 0), 1, 1, (k < 7) ? (8'h11 + k) : 8'hAA,
          8 - k, 0, 1, (1 + k) % 8);
    add(0, 0, 8'h00, 1,  1, 0, 0, 0,  0, 0, 1, 1);

    drive(1'b1, 1'b1, 8'h99, 1'b0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].msg, vecs[i].dr);
      check($sformatf("v%0d enq_rdy", i), 32'(enq_rdy), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d deq_val", i), 32'(deq_val), 32'(vecs[i].e_val));
      if (vecs[i].chk_msg)
        check($sformatf("v%0d deq_msg", i), 32'(deq_msg), 32'(vecs[i].e_msg));
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d mem_write_en", i), 32'(mem_write_en), 32'(vecs[i].e_wen));
      check($sformatf("v%0d mem_write_addr", i), 32'(mem_write_addr), 32'(vecs[i].e_wa));
      check($sformatf("v%0d mem_read_addr", i), 32'(mem_read_addr), 32'(vecs[i].e_ra));
      tick();
    end

    // Streaming at a constant occupancy of 3. Both pointers wrap several times.
    model.delete();
    for (int i = 0; i < 3; i++) begin
      m = 8'($urandom);
      drive(1'b0, 1'b1, m, 1'b0);
      model.push_back(m);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      m = 8'($urandom);
      drive(1'b0, 1'b1, m, 1'b1);
      check($sformatf("stream%0d count", i), 32'(count), 32'd3);
      check($sformatf("stream%0d deq_val", i), 32'(deq_val), 32'd1);
      check($sformatf("stream%0d enq_rdy", i), 32'(enq_rdy), 32'd1);
      check($sformatf("stream%0d deq_msg", i), 32'(deq_msg), 32'(model.pop_front()));
      model.push_back(m);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("tail%0d deq_msg", i), 32'(deq_msg), 32'(model.pop_front()));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("stream_end count", 32'(count), 32'd0);

    // An enqueue into an empty queue has no bypass path to the dequeue side.
    drive(1'b0, 1'b1, 8'h5C, 1'b1);
    check("lat cycleN deq_val", 32'(deq_val), 32'd0);
    check("lat cycleN mem_write_en", 32'(mem_write_en), 32'd1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("lat cycleN1 deq_val", 32'(deq_val), 32'd1);
    check("lat cycleN1 deq_msg", 32'(deq_msg), 32'h5C);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("lat end count", 32'(count), 32'd0);

    // Reset with 5 entries queued discards them all and returns both
    // pointers to slot 0.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid count before reset", 32'(count), 32'd5);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h33, 1'b0);
    check("mid reset count", 32'(count), 32'd0);
    check("mid reset deq_val", 32'(deq_val), 32'd0);
    check("mid reset write addr", 32'(mem_write_addr), 32'd0);
    check("mid reset write en", 32'(mem_write_en), 32'd1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("mid post deq_val", 32'(deq_val), 32'd1);
    check("mid post read addr", 32'(mem_read_addr), 32'd0);
    check("mid post deq_msg", 32'(deq_msg), 32'h33);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid end count", 32'(count), 32'd0);
    check("mid end deq_val", 32'(deq_val), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
